// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding fetch on an SRAM-like port, holds the
// returned instruction until ID accepts it, and squashes wrong-path fetches on redirect.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        cancel;

    logic        br_taken;
    logic [31:0] br_target;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // NOTE: all state is updated with non-blocking assignments so every branch
    // of the case reads the pre-edge values of fetch_pc/cancel, never a half-updated mix.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            fs_pc    <= 32'd0;
            fs_inst  <= 32'd0;
            cancel   <= 1'b0;
        end else begin
            // A redirect wins over the sequential +4 below (later assignment is skipped).
            if (br_taken) begin
                fetch_pc <= br_target;
            end

            case (state)
                S_REQ: begin
                    if (inst_sram_addr_ok) begin
                        fs_pc <= fetch_pc;
                        if (br_taken) begin
                            cancel <= 1'b1;
                        end else begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        if (cancel || br_taken) begin
                            cancel <= 1'b0;
                            state  <= S_REQ;
                        end else begin
                            fs_inst <= inst_sram_rdata;
                            state   <= S_HOLD;
                        end
                    end else if (br_taken) begin
                        cancel <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (br_taken || ds_allowin) begin
                        state <= S_REQ;
                    end
                end

                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is asserted, independent of register contents.
    assign inst_sram_req  = ~reset & (state == S_REQ);
    assign inst_sram_addr = reset ? 32'd0 : fetch_pc;
    assign fs_to_ds_valid = ~reset & (state == S_HOLD) & ~br_taken;
    assign fs_to_ds_bus   = reset ? 64'd0 : {fs_inst, fs_pc};

endmodule
